narrow_saturate: RTL and testbench
==================================

Name: narrow_saturate

Overview:
- Inverse of the datapath's 16→32 immediate sign extension: narrows 32-bit ALU/register values to 16 bits for halfword stores and immediate-range checks.
- Saturates when the value does not fit and flags the overflow.
- Two-stage elastic pipeline with valid/ready handshakes on both sides; sits between the ALU result bus and the halfword store path.
- Keeps a saturating count of overflow events for debug.

Parameters:
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents in_data/in_signed.
- in_ready  output  1  block accepts the input this cycle.
- in_data  input  32  value to narrow.
- in_signed  input  1  1 = signed (two's complement) narrowing; 0 = unsigned narrowing.
- out_valid  output  1  out_data/out_ovf are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  16  narrowed or saturated result.
- out_ovf  output  1  result was saturated.
- clr_count  input  1  synchronous clear of ovf_count.
- ovf_count  output  CNT_W  number of saturated results delivered.

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_ovf=0, ovf_count=0. in_ready goes high in the first cycle after reset deasserts.
- Reset mid-operation: in-flight data is discarded with no output; reset takes priority over everything.
- Stage 1 registers:
  - in_data[15:0]
  - in_signed
  - in_data[31]
  - fit flag:
    - signed: fit = (in_data[31:15] all 0) or (all 1)
    - unsigned: fit = (in_data[31:16] == 0)
- Stage 2 result:
  - fit: out_data = low 16 bits, out_ovf = 0.
  - signed, not fit: out_data = 16'h7FFF if bit31 = 0, else 16'h8000; out_ovf = 1.
  - unsigned, not fit: out_data = 16'hFFFF; out_ovf = 1.
- Handshake:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational from out_ready)
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_valid = s2_valid.
- Latency and throughput:
  - Input accepted at edge k → out_valid high after edge k+1.
  - Throughput 1 item/cycle while out_ready stays high.
- Back-pressure:
  - Both stages full and out_ready = 0 → in_ready = 0; out_data/out_ovf hold stable.
  - No item is dropped or duplicated.
  - s2 reloads from s1 on the same edge it drains.
- Emptying: s2 empties when it drains and s1 is empty; s1 empties when it moves to s2 with no new input.
- Round-trip property: for any fit result in signed mode, sign-extending out_data to 32 bits reproduces in_data exactly.
- ovf_count:
  - Increments on an output transfer with out_ovf = 1.
  - Sticks at all-ones (no wrap).
  - clr_count = 1 clears it to 0 and wins over a simultaneous increment.
- in_data/in_signed are ignored when no input transfer occurs; outputs hold when out_valid=0.

Test Plan:
- Reset then idle → out_valid=0, ovf_count=0, in_ready=1.
- Signed narrowing, out_ready=1, inputs 32'h00007FFF, 32'hFFFF8000, 32'h00008000, 32'h80000000 on consecutive cycles → outputs, 2 cycles after the first input, back-to-back:
  - 7FFF/ovf 0
  - 8000/ovf 0
  - 7FFF/ovf 1
  - 8000/ovf 1
  - then ovf_count=2.
- Unsigned narrowing: 32'h0000FFFF → FFFF/ovf 0; 32'h00010000 → FFFF/ovf 1; 32'hFFFFFFFF → FFFF/ovf 1.
- Back-pressure: stream 5 items with out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepted; out_data stays stable.
  - Releasing out_ready delivers all 5 in order, with no loss or duplication.
- Counter: preset ovf_count to FFFF via 65535 overflows (or CNT_W=4 build with 15 overflows) → one more overflow keeps it at all-ones; clr_count with a simultaneous overflow transfer → 0.
- Assert rst while both stages are valid → out_valid drops immediately; after release no stale output appears and the next input passes with 2-cycle latency.
- Random: 10k random in_data/in_signed/out_ready vs reference model; check saturation values and the round-trip property.

Source files
------------

// File: rtl/narrow_saturate.sv
// Narrows 32-bit ALU/register values to 16 bits with saturation and overflow flag.
// Two-stage valid/ready pipeline with a sticky saturating count of delivered overflows.
module narrow_saturate #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned OUT_W = 16;

  // Stage-1 payload: low half plus what stage 2 needs to pick a saturation value.
  typedef struct packed {
    logic [OUT_W-1:0] lo;
    logic             sgn;
    logic             msb;
    logic             fit;
  } s1_t;

  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             fit_c;
  logic             s2_load;
  logic             in_fire;
  logic             out_fire;
  logic [OUT_W-1:0] s2_data_c;
  logic             s2_ovf_c;

  // Handshake: s2 refills from s1 on the same edge it drains.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  // Range check against the 16-bit target.
  always_comb begin
    fit_c = 1'b0;
    if (in_signed) begin
      fit_c = (&in_data[31:15]) || !(|in_data[31:15]);
    end else begin
      fit_c = !(|in_data[31:16]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s2_load);
      if (in_fire) begin
        s1_q.lo  <= in_data[OUT_W-1:0];
        s1_q.sgn <= in_signed;
        s1_q.msb <= in_data[31];
        s1_q.fit <= fit_c;
      end
    end
  end

  // Result selection: pass-through when in range, else clamp to the nearest bound.
  always_comb begin
    s2_data_c = s1_q.lo;
    s2_ovf_c  = 1'b0;
    if (!s1_q.fit) begin
      s2_ovf_c = 1'b1;
      if (s1_q.sgn) begin
        s2_data_c = s1_q.msb ? 16'h8000 : 16'h7FFF;
      end else begin
        s2_data_c = 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out_data <= s2_data_c;
      out_ovf  <= s2_ovf_c;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Debug counter sticks at all-ones; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (out_fire && out_ovf && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_narrow_saturate.sv
// Directed and random checks of narrow_saturate (4-bit counter build so saturation is reachable).
module tb_narrow_saturate;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [31:0] din;
    logic        sgn;
    logic [15:0] d;
    logic        ovf;
  } item_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic             out_ovf;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  int               checks = 0;
  int               fails = 0;
  item_t            q[$];
  item_t            cur;
  logic             last_in_x = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;
  item_t            bp[5];
  int               idx;

  narrow_saturate #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input logic [31:0] d, input logic s,
                               input logic [15:0] ed, input logic eo);
    item_t e;
    e.din = d;
    e.sgn = s;
    e.d   = ed;
    e.ovf = eo;
    return e;
  endfunction

  function automatic item_t model(input logic [31:0] d, input logic s);
    logic fit;
    logic [15:0] v;
    fit = s ? ((&d[31:15]) || !(|d[31:15])) : !(|d[31:16]);
    if (fit)     v = d[15:0];
    else if (!s) v = 16'hFFFF;
    else         v = d[31] ? 16'h8000 : 16'h7FFF;
    return mk(d, s, v, !fit);
  endfunction

  // One clock: called at a negedge with inputs applied, returns at the next negedge.
  task automatic tick();
    logic  in_x;
    logic  out_x;
    item_t e;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    if (out_x) begin
      if (q.size() == 0) begin
        chk("spurious_output", 32'(out_data), 32'hDEAD_BEEF);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        if (e.sgn && !e.ovf) chk("round_trip", {{16{out_data[15]}}, out_data}, e.din);
        if (!rst && !clr_count && e.ovf && exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
      end
    end
    if (rst || clr_count) exp_cnt = '0;
    if (in_x) q.push_back(cur);
    last_in_x = in_x;
    @(posedge clk);
    @(negedge clk);
    chk("ovf_count", 32'(ovf_count), 32'(exp_cnt));
  endtask

  task automatic put(input item_t e);
    int n;
    in_valid  = 1'b1;
    in_data   = e.din;
    in_signed = e.sgn;
    cur       = e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_in_x && n < 16);
    if (!last_in_x) chk("put_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // Reset values while held in reset.
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Signed narrowing with latency check.
    put(mk(32'h0000_7FFF, 1'b1, 16'h7FFF, 1'b0));
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    put(mk(32'hFFFF_8000, 1'b1, 16'h8000, 1'b0));
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h7FFF);
    put(mk(32'h0000_8000, 1'b1, 16'h7FFF, 1'b1));
    put(mk(32'h8000_0000, 1'b1, 16'h8000, 1'b1));
    drain();
    chk("signed_count", 32'(ovf_count), 32'd2);

    // Unsigned narrowing.
    put(mk(32'h0000_FFFF, 1'b0, 16'hFFFF, 1'b0));
    put(mk(32'h0001_0000, 1'b0, 16'hFFFF, 1'b1));
    put(mk(32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b1));
    drain();
    chk("unsigned_count", 32'(ovf_count), 32'd4);

    // Back-pressure: 5 items, consumer stalled for 4 cycles.
    bp[0] = mk(32'h0000_0001, 1'b1, 16'h0001, 1'b0);
    bp[1] = mk(32'hFFFF_FFFE, 1'b1, 16'hFFFE, 1'b0);
    bp[2] = mk(32'h0012_3456, 1'b0, 16'hFFFF, 1'b1);
    bp[3] = mk(32'h0000_1234, 1'b0, 16'h1234, 1'b0);
    bp[4] = mk(32'hFFFF_0000, 1'b1, 16'h8000, 1'b1);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid  = 1'b1;
      in_data   = bp[idx].din;
      in_signed = bp[idx].sgn;
      cur       = bp[idx];
      tick();
      if (last_in_x) idx++;
      if (c >= 1) chk("bp_hold_data", 32'(out_data), 32'h0001);
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      in_valid  = 1'b1;
      in_data   = bp[idx].din;
      in_signed = bp[idx].sgn;
      cur       = bp[idx];
      tick();
      if (last_in_x) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 32'(idx), 32'd5);
    drain();
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(ovf_count), 32'd6);

    // Counter saturation at all-ones, then clear racing an overflow transfer.
    for (int i = 0; i < 9; i++) put(mk(32'h0002_0000, 1'b0, 16'hFFFF, 1'b1));
    drain();
    chk("cnt_full", 32'(ovf_count), 32'hF);
    put(mk(32'h7000_0000, 1'b1, 16'h7FFF, 1'b1));
    drain();
    chk("cnt_sticky", 32'(ovf_count), 32'hF);
    put(mk(32'h9000_0000, 1'b1, 16'h8000, 1'b1));
    tick();
    chk("clr_race_valid", 32'(out_valid), 32'd1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_wins", 32'(ovf_count), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    put(mk(32'h0000_0011, 1'b1, 16'h0011, 1'b0));
    put(mk(32'h0000_0022, 1'b1, 16'h0022, 1'b0));
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    q.delete();
    exp_cnt = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    put(mk(32'hFFFF_FF80, 1'b1, 16'hFF80, 1'b0));
    chk("post_rst_lat0", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_lat1", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'hFF80);
    drain();

    // Random traffic against the reference model.
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || last_in_x) begin
        logic [31:0] r;
        logic [31:0] d;
        logic        s;
        r = $urandom();
        case ($urandom_range(0, 3))
          0:       d = $urandom();
          1:       d = {{16{r[15]}}, r[15:0]};
          2:       d = {16'h0000, r[15:0]};
          default: d = {{15{r[16]}}, r[16:0]};
        endcase
        s         = 1'($urandom_range(0, 1));
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = d;
        in_signed = s;
        cur       = model(d, s);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_count = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid  = 1'b0;
    clr_count = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
